// File: rtl/uram_table_writer_pkg.sv
// Shared definitions for the exponentiation table writer.
// The read path uses the same state encoding for its state-aware debug view.
package uram_table_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } wr_state_e;

    localparam int DEF_WIDTH     = 3072;
    localparam int DEF_URAM_ADDR = 12;

endpackage

// File: rtl/uram_table_writer_if.sv
// Precompute entry stream plus the registered URAM write port.
// The writer takes the slave side; the environment takes the master side.
interface uram_table_writer_if #(
    parameter int WIDTH     = 3072,
    parameter int URAM_ADDR = 12
) ();

    logic                 in_valid;
    logic [WIDTH-1:0]     in_data;
    logic                 in_ready;
    logic                 wr_uram;
    logic [URAM_ADDR-1:0] wr_addr;
    logic [WIDTH-1:0]     data_wr;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output wr_uram,
        output wr_addr,
        output data_wr
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  wr_uram,
        input  wr_addr,
        input  data_wr
    );

endinterface

// File: rtl/uram_table_writer.sv
// Streams precomputed table entries into URAM addresses 0..count-1 and
// flags table_ready once the final write has been issued.
module uram_table_writer
    import uram_table_writer_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int URAM_ADDR = DEF_URAM_ADDR
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [URAM_ADDR:0]   entry_count,
    input  logic                 invalidate,
    uram_table_writer_if.slave   bus,
    output logic                 busy,
    output logic                 table_ready
);

    localparam logic [URAM_ADDR:0] CAP = {1'b1, {URAM_ADDR{1'b0}}};

    wr_state_e            state_q, state_d;
    logic [URAM_ADDR:0]   cnt_q, cnt_d;
    logic [URAM_ADDR:0]   len_q, len_d;
    logic                 wr_q, wr_d;
    logic [URAM_ADDR-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic                 hs;
    logic [URAM_ADDR:0]   len_clamped;

    assign len_clamped = (entry_count > CAP) ? CAP : entry_count;

    always_comb begin
        hs      = bus.in_valid & (state_q == ST_LOAD);
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        wr_d    = hs;
        addr_d  = hs ? cnt_q[URAM_ADDR-1:0] : addr_q;
        data_d  = hs ? bus.in_data : data_q;
        // start restarts from any state; a handshake in the same cycle still writes
        if (start) begin
            cnt_d   = '0;
            len_d   = len_clamped;
            state_d = (entry_count == '0) ? ST_DONE : ST_LOAD;
        end else begin
            unique case (state_q)
                ST_LOAD: begin
                    if (hs) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == len_q - 1'b1) begin
                            state_d = ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: state_d = ST_DONE;
                ST_DONE: begin
                    if (invalidate) begin
                        state_d = ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign bus.in_ready = (state_q == ST_LOAD);
    assign bus.wr_uram  = wr_q;
    assign bus.wr_addr  = addr_q;
    assign bus.data_wr  = data_q;
    assign busy         = (state_q == ST_LOAD) | (state_q == ST_FLUSH);
    assign table_ready  = (state_q == ST_DONE);

endmodule

// File: tb/tb_uram_table_writer.sv
// Directed bench for uram_table_writer, built with a 4-entry URAM
// so that the full-capacity and clamp cases are reachable.
module tb_uram_table_writer;

    localparam int W = 32;
    localparam int A = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [A:0]   entry_count = '0;
    logic         invalidate = 1'b0;
    logic         busy;
    logic         table_ready;
    int           passed = 0;
    int           total = 0;

    uram_table_writer_if #(.WIDTH(W), .URAM_ADDR(A)) bus ();

    uram_table_writer #(.WIDTH(W), .URAM_ADDR(A)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .entry_count (entry_count),
        .invalidate  (invalidate),
        .bus         (bus.slave),
        .busy        (busy),
        .table_ready (table_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    logic [31:0] va [4] = '{32'hA0A0_0001, 32'hB0B0_0002,
                            32'hC0C0_0003, 32'hD0D0_0004};
    logic [31:0] vb [4] = '{32'h1111_1111, 32'h2222_2222,
                            32'h3333_3333, 32'h4444_4444};
    logic        tog [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        int n;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        // reset state
        tick();
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("rst_wr_uram", {31'd0, bus.wr_uram}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ready", {31'd0, table_ready}, 32'd0);
        chk("rst_addr", {30'd0, bus.wr_addr}, 32'd0);
        chk("rst_data", bus.data_wr, 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: four entries back to back (also full capacity, no wrap)
        start = 1'b1;
        entry_count = 3'd4;
        tick();
        start = 1'b0;
        chk("t1_busy", {31'd0, busy}, 32'd1);
        chk("t1_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("t1_no_wr", {31'd0, bus.wr_uram}, 32'd0);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_data = va[i];
            tick();
            chk("t1_wr", {31'd0, bus.wr_uram}, 32'd1);
            chk("t1_addr", {30'd0, bus.wr_addr}, i);
            chk("t1_data", bus.data_wr, va[i]);
            chk("t1_not_ready", {31'd0, table_ready}, 32'd0);
        end
        chk("t1_flush_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("t1_flush_busy", {31'd0, busy}, 32'd1);
        bus.in_valid = 1'b0;
        tick();
        chk("t1_ready", {31'd0, table_ready}, 32'd1);
        chk("t1_done_wr", {31'd0, bus.wr_uram}, 32'd0);
        chk("t1_done_busy", {31'd0, busy}, 32'd0);
        chk("t1_hold_data", bus.data_wr, va[3]);

        // invalidate in DONE, then an empty table
        invalidate = 1'b1;
        tick();
        invalidate = 1'b0;
        chk("inv_ready", {31'd0, table_ready}, 32'd0);
        start = 1'b1;
        entry_count = 3'd0;
        tick();
        start = 1'b0;
        chk("t3_ready", {31'd0, table_ready}, 32'd1);
        chk("t3_no_wr", {31'd0, bus.wr_uram}, 32'd0);
        chk("t3_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("t3_no_wr2", {31'd0, bus.wr_uram}, 32'd0);

        // 2: three entries with gaps in in_valid
        start = 1'b1;
        entry_count = 3'd3;
        tick();
        start = 1'b0;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = tog[i];
            bus.in_data  = vb[i % 4] ^ 32'h00FF_0000;
            tick();
            chk("t2_wr", {31'd0, bus.wr_uram}, {31'd0, tog[i]});
            if (tog[i]) begin
                chk("t2_addr", {30'd0, bus.wr_addr}, n);
                chk("t2_data", bus.data_wr, vb[i % 4] ^ 32'h00FF_0000);
                n++;
            end
        end
        bus.in_valid = 1'b0;
        chk("t2_flush_in_ready", {31'd0, bus.in_ready}, 32'd0);
        tick();
        chk("t2_ready", {31'd0, table_ready}, 32'd1);

        // 4: count 7 clamped to 4
        start = 1'b1;
        entry_count = 3'd7;
        tick();
        start = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_data = vb[i];
            tick();
            chk("t4_addr", {30'd0, bus.wr_addr}, i);
            chk("t4_data", bus.data_wr, vb[i]);
        end
        chk("t4_in_ready", {31'd0, bus.in_ready}, 32'd0);
        tick();
        bus.in_valid = 1'b0;
        chk("t4_no_extra_wr", {31'd0, bus.wr_uram}, 32'd0);
        chk("t4_ready", {31'd0, table_ready}, 32'd1);

        // 5: restart mid-load after two entries
        start = 1'b1;
        entry_count = 3'd4;
        tick();
        start = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = va[0];
        tick();
        chk("t5_first_addr", {30'd0, bus.wr_addr}, 32'd0);
        bus.in_data = va[1];
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t5_pending_wr", {31'd0, bus.wr_uram}, 32'd1);
        chk("t5_pending_addr", {30'd0, bus.wr_addr}, 32'd1);
        chk("t5_pending_data", bus.data_wr, va[1]);
        for (int i = 0; i < 4; i++) begin
            bus.in_data = vb[i];
            tick();
            chk("t5_addr", {30'd0, bus.wr_addr}, i);
            chk("t5_data", bus.data_wr, vb[i]);
            chk("t5_not_ready", {31'd0, table_ready}, 32'd0);
        end
        bus.in_valid = 1'b0;
        tick();
        chk("t5_ready", {31'd0, table_ready}, 32'd1);

        // 6: async reset mid-load
        start = 1'b1;
        entry_count = 3'd4;
        tick();
        start = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = va[2];
        tick();
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_wr", {31'd0, bus.wr_uram}, 32'd0);
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        chk("t6_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("t6_rst_data", bus.data_wr, 32'd0);
        chk("t6_rst_ready", {31'd0, table_ready}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_after_ready", {31'd0, table_ready}, 32'd0);

        // start and invalidate together from DONE: start wins
        start = 1'b1;
        entry_count = 3'd0;
        tick();
        chk("t6_empty_ready", {31'd0, table_ready}, 32'd1);
        entry_count = 3'd2;
        invalidate = 1'b1;
        tick();
        start = 1'b0;
        invalidate = 1'b0;
        chk("t6_both_busy", {31'd0, busy}, 32'd1);
        chk("t6_both_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("t6_both_ready", {31'd0, table_ready}, 32'd0);

        // stall with no valid: no writes, still loading
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_no_wr", {31'd0, bus.wr_uram}, 32'd0);
        end
        chk("stall_busy", {31'd0, busy}, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
